// File: rtl/fetch_ctrl.sv
// fetch_ctrl: MIPS instruction-fetch stage with a single outstanding request, a one-entry skid buffer,
// a branch delay slot, flush handling and a misaligned-PC fault.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_addr_error
);
  typedef enum logic [2:0] {FETCH, WAIT, HOLD, DROP, ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, buf_pc_q, buf_pc_d, buf_inst_q, buf_inst_d;
  logic [31:0] redir_target_q, redir_target_d, if_pc_q, if_pc_d, if_inst_q, if_inst_d;
  logic redir_pending_q, redir_pending_d, if_valid_q, if_valid_d, if_err_q, if_err_d;
  logic consume, aligned, outstanding;
  assign consume = if_valid_q && !stall;
  assign aligned = pc_q[1:0] == 2'b00;
  assign imem_req = !rst && state_q == FETCH && aligned;
  assign imem_addr = pc_q;
  // a response is still owed by memory after this edge
  assign outstanding = ((state_q == WAIT || state_q == DROP) && !imem_rvalid) ||
                       (imem_req && imem_ready);
  assign if_valid = if_valid_q;
  assign if_pc = if_pc_q;
  assign if_instruction = if_inst_q;
  assign if_addr_error = if_err_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_pc_d = req_pc_q;
    buf_pc_d = buf_pc_q;
    buf_inst_d = buf_inst_q;
    redir_pending_d = redir_pending_q;
    redir_target_d = redir_target_q;
    if_valid_d = if_valid_q && !consume;
    if_pc_d = if_pc_q;
    if_inst_d = if_inst_q;
    if_err_d = if_err_q;
    if (flush) begin
      pc_d = flush_pc;
      if_valid_d = 1'b0;
      redir_pending_d = 1'b0;
      buf_pc_d = '0;
      buf_inst_d = '0;
      state_d = outstanding ? DROP : FETCH;
    end else begin
      case (state_q)
        FETCH:
          if (!aligned) begin
            if (!if_valid_q) begin
              if_valid_d = 1'b1;
              if_pc_d = pc_q;
              if_inst_d = '0;
              if_err_d = 1'b1;
              state_d = ERR;
            end
          end else if (imem_ready) begin
            req_pc_d = pc_q;
            pc_d = branch_taken ? branch_target : redir_pending_q ? redir_target_q : pc_q + 32'd4;
            redir_pending_d = 1'b0;
            state_d = WAIT;
          end else if (branch_taken) begin
            redir_pending_d = 1'b1;
            redir_target_d = branch_target;
          end
        WAIT: begin
          pc_d = branch_taken ? branch_target : pc_q;
          if (imem_rvalid && (!if_valid_q || consume)) begin
            if_valid_d = 1'b1;
            if_pc_d = req_pc_q;
            if_inst_d = imem_rdata;
            if_err_d = 1'b0;
            state_d = FETCH;
          end else if (imem_rvalid) begin
            buf_pc_d = req_pc_q;
            buf_inst_d = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD: begin
          pc_d = branch_taken ? branch_target : pc_q;
          if (consume) begin
            if_valid_d = 1'b1;
            if_pc_d = buf_pc_q;
            if_inst_d = buf_inst_q;
            if_err_d = 1'b0;
            state_d = FETCH;
          end
        end
        DROP: state_d = imem_rvalid ? FETCH : DROP;
        ERR: state_d = ERR;
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      if (outstanding) state_q <= DROP;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      buf_pc_q <= '0;
      buf_inst_q <= '0;
      redir_pending_q <= 1'b0;
      redir_target_q <= '0;
      if_valid_q <= 1'b0;
      if_pc_q <= '0;
      if_inst_q <= '0;
      if_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      buf_pc_q <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      redir_pending_q <= redir_pending_d;
      redir_target_q <= redir_target_d;
      if_valid_q <= if_valid_d;
      if_pc_q <= if_pc_d;
      if_inst_q <= if_inst_d;
      if_err_q <= if_err_d;
    end
  end
endmodule
